// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS pipeline. It detects load-use hazards,
// handles branch flush and EX back-pressure, and counts inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_dst_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_dst_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic rs_match;
  logic rt_match;
  logic load_use;
  logic bubble;

  // A load writing $0 produces nothing to wait for, so it can never cause a stall.
  assign rs_match = id_uses_rs && (id_rs_addr == ex_dst_addr);
  assign rt_match = id_uses_rt && (id_rt_addr == ex_dst_addr);
  assign load_use = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                    (ex_dst_addr != 5'd0) && (rs_match || rt_match);

  assign stall  = ex_hold || (load_use && !flush);
  assign bubble = flush || load_use;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of ex_* (load_use is built from them).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_dst_addr  <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      bubble_cnt   <= '0;
    end else if (ex_hold) begin
      // EX is frozen. A pending flush stays asserted upstream and is applied after the hold ends.
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_dst_addr  <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      // A flush takes priority, so a squashed load-use hazard is not counted.
      if (!flush && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_dst_addr  <= id_dst_addr;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      // An empty slot must never trigger memory reads, register writes or other control actions.
      ex_ctrl      <= id_valid ? id_ctrl : '0;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_reg_write <= id_valid && id_reg_write;
    end
  end

endmodule
